// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Purpose : Shared defaults and helpers for the single-clock FIFO.
//   DEF_WIDTH / DEF_DEPTH : default data width and entry count.
//   ptr_w(depth)          : pointer/count width, one bit wider than the
//                           memory address so the MSB can act as a wrap bit.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Purpose : depth x width register array for the FIFO, with one write port and
//           one combinational read port. Contents are never reset.
// Ports   :
//   clk    in  1       clock, write on posedge
//   we     in  1       write enable
//   waddr  in  AW      write address
//   wdata  in  width   write data
//   raddr  in  AW      read address
//   rdata  out width   read data (combinational from raddr)
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH,
    parameter int AW    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] r_mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : Single-clock synchronous FIFO with registered read data and
//           registered full/empty flags derived from the next-state count.
// Ports   :
//   clk            in  1      clock, all state updates on posedge
//   rst_           in  1      asynchronous reset, active-high
//   fifo_data_in   in  width  write data
//   fifo_write     in  1      write request (dropped while full)
//   fifo_read      in  1      read request (dropped while empty)
//   fifo_data_out  out width  registered read data, 1-clock latency
//   fifo_full      out 1      cnt == depth
//   fifo_empty     out 1      cnt == 0
// Configuration:
//   FIFO_ASSERT_EN : when defined, compiles concurrent SVA consistency checks.
// Internal cnt, wr_ptr and rd_ptr keep these exact names so an external
// checker can bind to them.
// -----------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [width-1:0] fifo_data_in,
    input  logic             fifo_write,
    input  logic             fifo_read,
    output logic [width-1:0] fifo_data_out,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(depth);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    cnt;
    logic [PW-1:0]    w_cnt_next;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [width-1:0] w_rdata;

    // Acceptance is gated by the registered flags: a write at full is dropped
    // even when a read is accepted in the same cycle (no bypass).
    assign w_wr_en = fifo_write && !fifo_full;
    assign w_rd_en = fifo_read  && !fifo_empty;

    always_comb begin
        w_cnt_next = cnt;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_cnt_next = cnt + 1'b1;
            2'b01:   w_cnt_next = cnt - 1'b1;
            default: w_cnt_next = cnt;
        endcase
    end

    sync_fifo_mem #(
        .width (width),
        .depth (depth),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (fifo_data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            fifo_data_out <= '0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
        end else begin
            if (w_wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                rd_ptr        <= rd_ptr + 1'b1;
                fifo_data_out <= w_rdata;
            end
            cnt <= w_cnt_next;
            // Flags come from the next count so they line up with the pointers.
            fifo_empty <= (w_cnt_next == '0);
            fifo_full  <= (w_cnt_next == DEPTH_CNT);
        end
    end

`ifdef FIFO_ASSERT_EN
    a_not_full_and_empty: assert property (
        @(posedge clk) disable iff (rst_) !(fifo_full && fifo_empty));

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (rst_) cnt <= DEPTH_CNT);

    a_cnt_matches_ptrs: assert property (
        @(posedge clk) disable iff (rst_) cnt == PW'(wr_ptr - rd_ptr));

    a_write_full_stable: assert property (
        @(posedge clk) disable iff (rst_)
        (fifo_write && fifo_full) |=> $stable(wr_ptr));

    a_read_empty_stable: assert property (
        @(posedge clk) disable iff (rst_)
        (fifo_read && fifo_empty) |=> ($stable(rd_ptr) && $stable(fifo_data_out)));
`else
    // Assertions not compiled; behaviour is identical.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Purpose : Directed self-checking bench for sync_fifo (width=16, depth=16).
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    logic        clk;
    logic        rst_;
    logic [15:0] fifo_data_in;
    logic        fifo_write;
    logic        fifo_read;
    logic [15:0] fifo_data_out;
    logic        fifo_full;
    logic        fifo_empty;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_q[$];
    logic [15:0] exp_out;

    sync_fifo #(
        .width (16),
        .depth (16)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .fifo_data_in  (fifo_data_in),
        .fifo_write    (fifo_write),
        .fifo_read     (fifo_read),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the currently driven inputs; outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
        $display("txn rst=%0b wr=%0b rd=%0b din=%0d out=%0d cnt=%0d full=%0b empty=%0b",
                 rst_, fifo_write, fifo_read, fifo_data_in, fifo_data_out,
                 dut.cnt, fifo_full, fifo_empty);
    endtask

    initial begin
        rst_         = 1'b1;
        fifo_write   = 1'b1;
        fifo_read    = 1'b0;
        fifo_data_in = 16'd7;

        // 1. Write requested while reset held: ignored.
        step();
        check_val("rst_empty", fifo_empty, 1);
        check_val("rst_full", fifo_full, 0);
        check_val("rst_out", fifo_data_out, 0);
        check_val("rst_wr_ptr", dut.wr_ptr, 0);
        check_val("rst_rd_ptr", dut.rd_ptr, 0);
        check_val("rst_cnt", dut.cnt, 0);

        // 2. Write 7, then read it back.
        rst_ = 1'b0;
        step();
        fifo_write = 1'b0;
        check_val("w7_cnt", dut.cnt, 1);
        check_val("w7_empty", fifo_empty, 0);
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        check_val("r7_out", fifo_data_out, 7);
        check_val("r7_empty", fifo_empty, 1);

        // Empty with write+read: only the write is accepted, out unchanged.
        fifo_write = 1'b1; fifo_read = 1'b1; fifo_data_in = 16'd55;
        step();
        fifo_write = 1'b0; fifo_read = 1'b0;
        check_val("ewr_cnt", dut.cnt, 1);
        check_val("ewr_out", fifo_data_out, 7);
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        check_val("ewr_read_out", fifo_data_out, 55);
        check_val("ewr_read_empty", fifo_empty, 1);

        // Reset pulse so pointers restart at zero.
        rst_ = 1'b1;
        step();
        rst_ = 1'b0;

        // 3. Fill with 0..15.
        for (int i = 0; i < 16; i++) begin
            fifo_write   = 1'b1;
            fifo_data_in = 16'(i);
            step();
            if (i == 14) check_val("fill15_full", fifo_full, 0);
        end
        fifo_write = 1'b0;
        check_val("fill_full", fifo_full, 1);
        check_val("fill_wr_ptr", dut.wr_ptr, 16);
        check_val("fill_cnt", dut.cnt, 16);
        check_val("fill_out_hold", fifo_data_out, 0);

        // 4. Write while full: dropped.
        fifo_write = 1'b1; fifo_data_in = 16'd99;
        step();
        fifo_write = 1'b0;
        check_val("wfull_cnt", dut.cnt, 16);
        check_val("wfull_full", fifo_full, 1);
        check_val("wfull_wr_ptr", dut.wr_ptr, 16);

        // 5. Drain 16 words in order, then one extra read.
        fifo_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check_val($sformatf("drain_out%0d", i), fifo_data_out, i);
        end
        check_val("drain_empty", fifo_empty, 1);
        check_val("drain_full", fifo_full, 0);
        step();
        fifo_read = 1'b0;
        check_val("extra_rd_out", fifo_data_out, 15);
        check_val("extra_rd_ptr", dut.rd_ptr, 16);

        // 6. Half full then 20 simultaneous write+read cycles across the wrap.
        for (int i = 0; i < 8; i++) begin
            fifo_write   = 1'b1;
            fifo_data_in = 16'(100 + i);
            model_q.push_back(16'(100 + i));
            step();
        end
        check_val("half_cnt", dut.cnt, 8);
        fifo_read = 1'b1;
        for (int k = 0; k < 20; k++) begin
            fifo_data_in = 16'(108 + k);
            step();
            exp_out = model_q.pop_front();
            model_q.push_back(16'(108 + k));
            check_val($sformatf("burst_out%0d", k), fifo_data_out, exp_out);
            check_val($sformatf("burst_cnt%0d", k), dut.cnt, 8);
        end
        check_val("burst_wr_ptr", dut.wr_ptr, 12);

        // Asynchronous reset mid-burst, between clock edges.
        #2;
        rst_ = 1'b1;
        #1;
        check_val("async_rst_empty", fifo_empty, 1);
        check_val("async_rst_out", fifo_data_out, 0);
        check_val("async_rst_cnt", dut.cnt, 0);
        check_val("async_rst_full", fifo_full, 0);
        step();
        check_val("held_rst_cnt", dut.cnt, 0);
        check_val("held_rst_wr_ptr", dut.wr_ptr, 0);
        fifo_write = 1'b0; fifo_read = 1'b0;
        rst_ = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
